// File: rtl/speedpong_pkg.sv
// Shared SpeedPong types and screen geometry used by the paddle, ball and AI blocks.
package speedpong_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } dir_t;

    localparam int SCREEN_H_DEF = 480;
    localparam int PADDLE_H_DEF = 64;

endpackage

// File: rtl/paddle_speed_ramp.sv
// Paddle speed ramp: restarts at V_MIN on a new direction and gains one step
// every ACCEL_FRAMES continuation ticks, capped at V_MAX.
module paddle_speed_ramp #(
    parameter int V_MIN        = 1,
    parameter int V_MAX        = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       cont,
    input  logic       stop,
    output logic [3:0] speed,
    output logic [3:0] speed_nxt
);

    localparam int CNT_W = $clog2(ACCEL_FRAMES + 1);
    localparam logic [3:0] VMIN4 = 4'(V_MIN);
    localparam logic [3:0] VMAX4 = 4'(V_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);

    generate
        if (ACCEL_FRAMES < 1 || V_MIN < 1 || V_MIN > V_MAX || V_MAX > 15) begin : g_param_err
            $error("paddle_speed_ramp: illegal parameter set");
        end
    endgenerate

    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // speed_nxt is exported so the position update can use the post-ramp speed on the same tick
    always_comb begin
        speed_nxt = speed;
        cnt_nxt   = hold_cnt;
        if (stop) begin
            speed_nxt = 4'd0;
            cnt_nxt   = '0;
        end else if (start) begin
            speed_nxt = VMIN4;
            cnt_nxt   = '0;
        end else if (cont) begin
            if (hold_cnt == CNT_LAST) begin
                cnt_nxt   = '0;
                speed_nxt = (speed >= VMAX4) ? VMAX4 : speed + 4'd1;
            end else begin
                cnt_nxt = hold_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed    <= 4'd0;
            hold_cnt <= '0;
        end else if (tick) begin
            speed    <= speed_nxt;
            hold_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/paddle_accel.sv
// SpeedPong paddle controller: resolves manual/auto direction, runs the IDLE/UP/DN
// FSM and moves the paddle once per frame tick with edge clamping.
module paddle_accel
    import speedpong_pkg::*;
#(
    parameter int Y_W          = 10,
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int PADDLE_H     = PADDLE_H_DEF,
    parameter int Y_INIT       = (SCREEN_H - PADDLE_H) / 2,
    parameter int V_MIN        = 1,
    parameter int V_MAX        = 8,
    parameter int ACCEL_FRAMES = 4,
    parameter int DEADZONE     = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic           up,
    input  logic           down,
    input  logic           auto_en,
    input  logic [Y_W-1:0] ball_y,
    output logic [Y_W-1:0] y1,
    output logic [Y_W-1:0] y2,
    output logic [3:0]     speed,
    output logic           moving
);

    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(SCREEN_H - PADDLE_H);
    localparam logic [Y_W+1:0] HALF_H  = (Y_W+2)'(PADDLE_H / 2);
    localparam logic [Y_W+1:0] DZ      = (Y_W+2)'(DEADZONE);

    generate
        if (PADDLE_H >= SCREEN_H || V_MIN > V_MAX || V_MAX > 15 || SCREEN_H > 2**Y_W) begin : g_param_err
            $error("paddle_accel: illegal parameter set");
        end
    endgenerate

    dir_t           state;
    dir_t           req;
    logic           start, cont, stop;
    logic [3:0]     speed_nxt;
    logic [Y_W-1:0] y1_nxt;
    logic [Y_W-1:0] step;
    logic [Y_W:0]   sum_dn;
    logic [Y_W+1:0] centre, ball_w;

    // Widened so centre +/- DEADZONE never wraps
    assign centre = {2'b00, y1} + HALF_H;
    assign ball_w = {2'b00, ball_y};

    always_comb begin
        req = IDLE;
        if (auto_en) begin
            if (ball_w + DZ < centre)
                req = UP;
            else if (ball_w > centre + DZ)
                req = DN;
        end else begin
            case ({up, down})
                2'b10:   req = UP;
                2'b01:   req = DN;
                default: req = IDLE;
            endcase
        end
    end

    always_comb begin
        stop  = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        if (req == IDLE)
            stop = 1'b1;
        else if (req != state)
            start = 1'b1;
        else
            cont = 1'b1;
    end

    paddle_speed_ramp #(
        .V_MIN        (V_MIN),
        .V_MAX        (V_MAX),
        .ACCEL_FRAMES (ACCEL_FRAMES)
    ) u_ramp (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .cont      (cont),
        .stop      (stop),
        .speed     (speed),
        .speed_nxt (speed_nxt)
    );

    assign step   = Y_W'(speed_nxt);
    assign sum_dn = {1'b0, y1} + {1'b0, step};

    always_comb begin
        y1_nxt = y1;
        case (req)
            UP:      y1_nxt = (y1 < step) ? '0 : y1 - step;
            DN:      y1_nxt = (sum_dn > {1'b0, Y_MAX}) ? Y_MAX : sum_dn[Y_W-1:0];
            default: y1_nxt = y1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            y1    <= Y_W'(Y_INIT);
            y2    <= Y_W'(Y_INIT + PADDLE_H - 1);
        end else if (tick) begin
            state <= req;
            y1    <= y1_nxt;
            y2    <= y1_nxt + Y_W'(PADDLE_H - 1);
        end
    end

    assign moving = (state != IDLE);

endmodule

// File: tb/tb_paddle_accel.sv
// Randomised and directed bench for paddle_accel against a per-tick behavioural model.
module tb_paddle_accel;

    localparam int PH   = 64;
    localparam int YI   = 208;
    localparam int VMIN = 1;
    localparam int VMAX = 8;
    localparam int ACC  = 4;
    localparam int DZ   = 4;
    localparam int YMAX = 416;

    logic       clk, reset, tick, up, down, auto_en;
    logic [9:0] ball_y, y1, y2;
    logic [3:0] speed;
    logic       moving;
    logic [24:0] got;

    int checks = 0;
    int errors = 0;
    int my, msp, mhold, mdir;

    paddle_accel dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .up      (up),
        .down    (down),
        .auto_en (auto_en),
        .ball_y  (ball_y),
        .y1      (y1),
        .y2      (y2),
        .speed   (speed),
        .moving  (moving)
    );

    assign got = {y1, y2, speed, moving};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        my = YI; msp = 0; mhold = 0; mdir = 0;
    endfunction

    // One frame of paddle behaviour; mdir 0=idle 1=up 2=down
    function automatic void model_step();
        int req, c;
        if (auto_en) begin
            c = my + PH / 2;
            if (int'(ball_y) < c - DZ) req = 1;
            else if (int'(ball_y) > c + DZ) req = 2;
            else req = 0;
        end else if (up && !down) req = 1;
        else if (down && !up) req = 2;
        else req = 0;
        if (req == 0) begin
            mdir = 0; msp = 0; mhold = 0;
        end else if (req != mdir) begin
            mdir = req; msp = VMIN; mhold = 0;
        end else begin
            mhold++;
            if (mhold == ACC) begin
                mhold = 0;
                msp = (msp + 1 > VMAX) ? VMAX : msp + 1;
            end
        end
        if (mdir == 1) my = (my < msp) ? 0 : my - msp;
        else if (mdir == 2) my = (my + msp > YMAX) ? YMAX : my + msp;
    endfunction

    function automatic logic [24:0] model_vec();
        return {10'(my), 10'(my + PH - 1), 4'(msp), (mdir != 0)};
    endfunction

    task automatic do_tick(input int gap);
        repeat (gap - 1) @(negedge clk);
        tick = 1'b1;
        model_step();
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; tick = 1'b0; up = 1'b0; down = 1'b0; auto_en = 1'b0; ball_y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (got !== {10'd208, 10'd271, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: y1=%0d y2=%0d speed=%0d moving=%0d expected 208 271 0 0", y1, y2, speed, moving);
        end
    endtask

    task automatic test_up_ramp();
        int ey[5] = '{207, 206, 205, 204, 202};
        int es[5] = '{1, 1, 1, 1, 2};
        up = 1'b1; down = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_tick(10);
            checks++;
            if (got !== {10'(ey[i]), 10'(ey[i] + 63), 4'(es[i]), 1'b1}) begin
                errors++;
                $display("FAIL up_ramp[%0d]: y1=%0d y2=%0d speed=%0d moving=%0d expected %0d %0d %0d 1",
                         i, y1, y2, speed, moving, ey[i], ey[i] + 63, es[i]);
            end
        end
    endtask

    task automatic test_down_saturate();
        up = 1'b0; down = 1'b1;
        for (int i = 0; i < 80; i++) begin
            do_tick(10);
            checks++;
            if (got !== model_vec() || y2 > 10'd479) begin
                errors++;
                $display("FAIL down_tick[%0d]: y1=%0d y2=%0d speed=%0d moving=%0d expected %0d %0d %0d %0d",
                         i, y1, y2, speed, moving, my, my + 63, msp, mdir != 0);
            end
        end
        checks++;
        if (got !== {10'd416, 10'd479, 4'd8, 1'b1}) begin
            errors++;
            $display("FAIL down_final: y1=%0d y2=%0d speed=%0d expected 416 479 8", y1, y2, speed);
        end
    endtask

    task automatic test_up_clamp();
        up = 1'b1; down = 1'b0;
        for (int i = 0; i < 80; i++) begin
            do_tick(10);
            checks++;
            if (got !== model_vec()) begin
                errors++;
                $display("FAIL up_clamp_tick[%0d]: y1=%0d speed=%0d moving=%0d expected %0d %0d %0d",
                         i, y1, speed, moving, my, msp, mdir != 0);
            end
        end
        checks++;
        if (got !== {10'd0, 10'd63, 4'd8, 1'b1}) begin
            errors++;
            $display("FAIL up_clamp_final: y1=%0d y2=%0d speed=%0d moving=%0d expected 0 63 8 1", y1, y2, speed, moving);
        end
    endtask

    task automatic test_both_and_reversal();
        logic [9:0] prev;
        up = 1'b0; down = 1'b1;
        for (int i = 0; i < 20; i++) do_tick(10);
        checks++;
        if (got !== model_vec()) begin
            errors++;
            $display("FAIL pre_both: y1=%0d speed=%0d expected %0d %0d", y1, speed, my, msp);
        end
        prev = y1;
        up = 1'b1; down = 1'b1;
        do_tick(10);
        checks++;
        if ({y1, speed, moving} !== {prev, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL both_pressed: y1=%0d speed=%0d moving=%0d expected %0d 0 0", y1, speed, moving, prev);
        end
        up = 1'b1; down = 1'b0;
        for (int i = 0; i < 9; i++) do_tick(10);
        checks++;
        if (speed !== 4'd3 || got !== model_vec()) begin
            errors++;
            $display("FAIL up_to_speed3: y1=%0d speed=%0d expected %0d 3", y1, speed, my);
        end
        prev = y1;
        up = 1'b0; down = 1'b1;
        do_tick(10);
        checks++;
        if ({y1, speed, moving} !== {prev + 10'd1, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL reversal: y1=%0d speed=%0d moving=%0d expected %0d 1 1", y1, speed, moving, prev + 10'd1);
        end
    endtask

    task automatic test_auto();
        int d;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        auto_en = 1'b1; ball_y = 10'd100;
        for (int i = 0; i < 200; i++) begin
            up = 1'($urandom); down = 1'($urandom);
            do_tick(10);
            checks++;
            if (got !== model_vec()) begin
                errors++;
                $display("FAIL auto_tick[%0d]: y1=%0d speed=%0d moving=%0d expected %0d %0d %0d",
                         i, y1, speed, moving, my, msp, mdir != 0);
            end
            if (mdir == 0) break;
        end
        d = int'(y1) + 32 - 100;
        checks++;
        if (moving !== 1'b0 || d > DZ || d < -DZ) begin
            errors++;
            $display("FAIL auto_settle: y1=%0d moving=%0d expected |y1+32-100|<=4 and moving 0", y1, moving);
        end
        auto_en = 1'b0;
    endtask

    task automatic test_async_reset();
        up = 1'b0; down = 1'b1;
        for (int i = 0; i < 6; i++) do_tick(10);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (got !== {10'd208, 10'd271, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: y1=%0d y2=%0d speed=%0d moving=%0d expected 208 271 0 0", y1, y2, speed, moving);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            up = 1'($urandom); down = 1'($urandom);
            auto_en = ($urandom_range(0, 3) == 0);
            ball_y = 10'($urandom_range(0, 479));
            do_tick(1);
            checks++;
            if (got !== model_vec()) begin
                errors++;
                $display("FAIL rand_tick[%0d]: y1=%0d y2=%0d speed=%0d moving=%0d expected %0d %0d %0d %0d",
                         i, y1, y2, speed, moving, my, my + 63, msp, mdir != 0);
            end
            up = 1'($urandom); down = 1'($urandom); auto_en = 1'($urandom);
            ball_y = 10'($urandom_range(0, 479));
            repeat ($urandom_range(1, 10)) @(negedge clk);
            checks++;
            if (got !== model_vec()) begin
                errors++;
                $display("FAIL rand_hold[%0d]: y1=%0d speed=%0d moving=%0d expected %0d %0d %0d",
                         i, y1, speed, moving, my, msp, mdir != 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_down_saturate();
        test_up_clamp();
        test_both_and_reversal();
        test_auto();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
